// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART core.
//   Configurable data width (5..9), parity (none/odd/even) and stop bits (1/2).
//   The transmitter and receiver share one 16x-oversampling tick generator.
//   The receiver takes a majority vote of ticks 7, 8 and 9 of every bit.
// Ports:
//   clk, rst         system clock; asynchronous active-high reset
//   tx_data/valid    word to send, accepted when tx_valid && tx_ready
//   tx_ready         transmitter idle
//   txd              serial out, idle high
//   rxd              serial in, asynchronous to clk
//   rx_data/valid    last received word; rx_valid cleared by rx_ready
//   rx_frame_err     stop bit sampled low (qualified by rx_valid)
//   rx_parity_err    parity mismatch (qualified by rx_valid)
//   rx_overrun       1-cycle pulse when an unconsumed word is overwritten
module uart_core_param #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS + 1);

  if (DIV < 2) begin : g_div_err
    $error("uart_core_param: CLK_FREQ/(BAUD_RATE*16) must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_dbits_err
    $error("uart_core_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_err
    $error("uart_core_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_err
    $error("uart_core_param: STOP_BITS must be 1 or 2");
  end

  // ---------------- tick generator ----------------
  logic [CW-1:0] div_cnt;
  logic          tick16;

  assign tick16 = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         div_cnt <= '0;
    else if (tick16) div_cnt <= '0;
    else             div_cnt <= div_cnt + CW'(1);
  end

  // ---------------- transmitter ----------------
  // T_ARM holds an accepted word until the next tick16 so that every bit,
  // including the start bit, is exactly 16 tick periods long.
  typedef enum logic [2:0] {T_IDLE, T_ARM, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  tx_state_t            t_state, t_state_n;
  logic [3:0]           t_tick;
  logic [BW-1:0]        t_bidx;
  logic [DATA_BITS-1:0] t_sh;
  logic                 t_par;
  logic                 t_bit_end;

  assign t_bit_end = tick16 && (t_tick == 4'd15);
  assign tx_ready  = (t_state == T_IDLE);

  always_comb begin
    t_state_n = t_state;
    txd       = 1'b1;
    case (t_state)
      T_IDLE:  if (tx_valid) t_state_n = T_ARM;
      T_ARM:   if (tick16) t_state_n = T_START;
      T_START: begin
        txd = 1'b0;
        if (t_bit_end) t_state_n = T_DATA;
      end
      T_DATA: begin
        txd = t_sh[0];
        if (t_bit_end && t_bidx == BW'(DATA_BITS - 1))
          t_state_n = (PARITY != 0) ? T_PAR : T_STOP;
      end
      T_PAR: begin
        txd = t_par;
        if (t_bit_end) t_state_n = T_STOP;
      end
      T_STOP:  if (t_bit_end && t_bidx == BW'(STOP_BITS - 1)) t_state_n = T_IDLE;
      default: t_state_n = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_state <= T_IDLE;
      t_tick  <= '0;
      t_bidx  <= '0;
      t_sh    <= '0;
      t_par   <= 1'b0;
    end else begin
      t_state <= t_state_n;
      if (t_state == T_IDLE && tx_valid) begin
        t_sh  <= tx_data;
        t_par <= (^tx_data) ^ (PARITY == 1);
      end
      if (t_state == T_ARM) begin
        t_tick <= '0;
        t_bidx <= '0;
      end else if (tick16) begin
        t_tick <= t_tick + 4'd1;
        if (t_tick == 4'd15) begin
          if (t_state == T_DATA) begin
            t_sh   <= t_sh >> 1;
            // wrap to 0 so the same index counts stop bits afterwards
            t_bidx <= (t_bidx == BW'(DATA_BITS - 1)) ? '0 : t_bidx + BW'(1);
          end else if (t_state == T_STOP) begin
            t_bidx <= t_bidx + BW'(1);
          end
        end
      end
    end
  end

  // ---------------- receiver ----------------
  logic [1:0] sync;
  logic       rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rxd};
  end
  assign rxs = sync[1];

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;
  rx_state_t            r_state, r_state_n;
  logic [3:0]           r_tick;
  logic [BW-1:0]        r_bidx;
  logic [DATA_BITS-1:0] r_sh;
  logic [1:0]           r_smp;   // samples from ticks 7 and 8
  logic                 r_par;
  logic                 r_mid, r_bit_end, vote, deliver;

  assign r_mid     = tick16 && (r_tick == 4'd9);
  assign r_bit_end = tick16 && (r_tick == 4'd15);
  // third vote is the live sample at tick 9
  assign vote = (r_smp[1] & r_smp[0]) | (r_smp[1] & rxs) | (r_smp[0] & rxs);

  always_comb begin
    r_state_n = r_state;
    deliver   = 1'b0;
    case (r_state)
      R_IDLE:  if (tick16 && !rxs) r_state_n = R_START;
      R_START: begin
        if (r_mid && vote)  r_state_n = R_IDLE;   // glitch, not a start bit
        else if (r_bit_end) r_state_n = R_DATA;
      end
      R_DATA: begin
        if (r_bit_end && r_bidx == BW'(DATA_BITS - 1))
          r_state_n = (PARITY != 0) ? R_PAR : R_STOP;
      end
      R_PAR:   if (r_bit_end) r_state_n = R_STOP;
      R_STOP: begin
        if (r_mid) begin
          deliver   = 1'b1;
          // a low stop bit may be a break; wait for the line to recover
          r_state_n = vote ? R_IDLE : R_WAIT;
        end
      end
      R_WAIT:  if (tick16 && rxs) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= R_IDLE;
      r_tick        <= '0;
      r_bidx        <= '0;
      r_sh          <= '0;
      r_smp         <= 2'b11;
      r_par         <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      r_state    <= r_state_n;
      rx_overrun <= 1'b0;
      // tick count is 0 on the tick that detected the start edge
      if (r_state == R_IDLE) r_tick <= '0;
      else if (tick16)       r_tick <= r_tick + 4'd1;
      if (r_state == R_IDLE)                    r_bidx <= '0;
      else if (r_state == R_DATA && r_bit_end)  r_bidx <= r_bidx + BW'(1);
      if (tick16 && (r_tick == 4'd7 || r_tick == 4'd8)) r_smp <= {r_smp[0], rxs};
      if (r_mid && r_state == R_DATA) r_sh  <= {vote, r_sh[DATA_BITS-1:1]};
      if (r_mid && r_state == R_PAR)  r_par <= vote;
      if (deliver) begin
        rx_data       <= r_sh;
        rx_valid      <= 1'b1;
        rx_frame_err  <= ~vote;
        rx_parity_err <= (PARITY != 0) && (r_par != ((^r_sh) ^ (PARITY == 1)));
        // a same-cycle rx_ready consumes the old word, so no overrun then
        rx_overrun    <= rx_valid && !rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: an 8N1 instance and an even-parity instance, both
// at DIV=2 (32 clk per bit). Each RX input selects loopback from its own txd
// or a bench-driven line. Expected words go into a scoreboard queue when the
// stimulus is driven and are popped when the receiver delivers.
module tb_uart_core_param;
  localparam int CF  = 32000000;
  localparam int BR  = 1000000;
  localparam int BIT = 32;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_data_a, tx_data_b, rx_data_a, rx_data_b;
  logic tx_valid_a, tx_valid_b, tx_ready_a, tx_ready_b, txd_a, txd_b, rxd_a, rxd_b;
  logic rx_valid_a, rx_valid_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;
  logic rx_ready, drv, loop_a, loop_b;

  assign rxd_a = loop_a ? txd_a : drv;
  assign rxd_b = loop_b ? txd_b : drv;

  uart_core_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .txd(txd_a), .rxd(rxd_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready),
    .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_overrun(ov_a));

  uart_core_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .txd(txd_b), .rxd(rxd_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready),
    .rx_frame_err(fe_b), .rx_parity_err(pe_b), .rx_overrun(ov_b));

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  function automatic logic rvalid(input bit s); return s ? rx_valid_b : rx_valid_a; endfunction
  function automatic logic [7:0] rdata(input bit s); return s ? rx_data_b : rx_data_a; endfunction
  function automatic logic rfe(input bit s); return s ? fe_b : fe_a; endfunction
  function automatic logic rpe(input bit s); return s ? pe_b : pe_a; endfunction
  function automatic logic rtxd(input bit s); return s ? txd_b : txd_a; endfunction
  function automatic logic rtxrdy(input bit s); return s ? tx_ready_b : tx_ready_a; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_rx(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d; e.fe = fe; e.pe = pe;
    sb.push_back(e);
  endtask

  task automatic send_tx(input bit s, input logic [7:0] d);
    int n = 0;
    while (!rtxrdy(s) && n < 20*BIT) begin @(negedge clk); n++; end
    chk("send_tx.ready", 32'(rtxrdy(s)), 32'd1);
    if (s) begin tx_data_b = d; tx_valid_b = 1'b1; end
    else   begin tx_data_a = d; tx_valid_a = 1'b1; end
    @(negedge clk);
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
  endtask

  // samples txd mid-bit for a whole frame after the start edge
  task automatic check_line(input bit s, input logic [7:0] d, input bit par_en, input string tag);
    int n = 0;
    int nb;
    logic [10:0] bits;
    while (rtxd(s) && n < 4*BIT) begin @(negedge clk); n++; end
    chk({tag, ".start_edge"}, 32'(rtxd(s)), 32'd0);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (par_en) bits[9] = ^d;
    nb = par_en ? 11 : 10;
    cyc_n(BIT/2);
    for (int k = 0; k < nb; k++) begin
      chk($sformatf("%s.bit%0d", tag, k), 32'(rtxd(s)), 32'(bits[k]));
      if (k != nb-1) cyc_n(BIT);
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input bit par_en, input logic par, input logic stop);
    drv = 1'b0; cyc_n(BIT);
    for (int i = 0; i < 8; i++) begin drv = d[i]; cyc_n(BIT); end
    if (par_en) begin drv = par; cyc_n(BIT); end
    drv = stop; cyc_n(BIT);
  endtask

  task automatic wait_rx(input bit s, input string tag);
    int n = 0;
    while (!rvalid(s) && n < 20*BIT) begin @(negedge clk); n++; end
    chk({tag, ".rx_valid"}, 32'(rvalid(s)), 32'd1);
  endtask

  task automatic check_rx(input bit s, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".data"}, 32'(rdata(s)), 32'(e.data));
    chk({tag, ".frame_err"}, 32'(rfe(s)), 32'(e.fe));
    chk({tag, ".parity_err"}, 32'(rpe(s)), 32'(e.pe));
  endtask

  task automatic consume(input bit s, input string tag);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk({tag, ".consumed"}, 32'(rvalid(s)), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int lat;
    tx_data_a = '0; tx_valid_a = 1'b0; tx_data_b = '0; tx_valid_b = 1'b0;
    drv = 1'b1; rx_ready = 1'b0; loop_a = 1'b1; loop_b = 1'b1;
    rst = 1'b1;
    cyc_n(3);
    chk("rst.txd", 32'(txd_a), 32'd1);
    chk("rst.tx_ready", 32'(tx_ready_a), 32'd1);
    chk("rst.rx_valid", 32'(rx_valid_a), 32'd0);
    chk("rst.rx_data", 32'(rx_data_a), 32'd0);
    chk("rst.flags", 32'({fe_a, pe_a, ov_a, fe_b, pe_b, ov_b}), 32'd0);
    @(negedge clk); rst = 1'b0;
    cyc_n(4);

    // 1: 8N1 loopback 0xA5
    send_tx(0, 8'hA5);
    lat = cyc;
    chk("t1.tx_busy", 32'(tx_ready_a), 32'd0);
    expect_rx(8'hA5, 1'b0, 1'b0);
    check_line(0, 8'hA5, 0, "t1");
    n = 0;
    while (!tx_ready_a && n < 4*BIT) begin @(negedge clk); n++; end
    lat = cyc - lat;
    chk("t1.tx_ready_latency_320_322", 32'(lat >= 320 && lat <= 322), 32'd1);
    wait_rx(0, "t1");
    chk("t1.overrun", 32'(ov_a), 32'd0);
    check_rx(0, "t1");
    consume(0, "t1");
    chk("t1.data_held", 32'(rx_data_a), 32'hA5);

    // 2: even parity loopback 0x07, then parity bit forced low
    send_tx(1, 8'h07);
    expect_rx(8'h07, 1'b0, 1'b0);
    check_line(1, 8'h07, 1, "t2");
    wait_rx(1, "t2");
    check_rx(1, "t2");
    consume(1, "t2");
    loop_b = 1'b0;
    cyc_n(BIT);
    expect_rx(8'h07, 1'b0, 1'b1);
    drive_frame(8'h07, 1, 1'b0, 1'b1);
    wait_rx(1, "t2f");
    check_rx(1, "t2f");
    consume(1, "t2f");

    // 3: stop bit low followed by a long break
    loop_a = 1'b0;
    cyc_n(BIT);
    expect_rx(8'h3C, 1'b1, 1'b0);
    drive_frame(8'h3C, 0, 1'b0, 1'b0);
    wait_rx(0, "t3");
    check_rx(0, "t3");
    consume(0, "t3");
    cyc_n(4*BIT);
    chk("t3.no_restart_low", 32'(rx_valid_a), 32'd0);
    drv = 1'b1;
    cyc_n(12*BIT);
    chk("t3.no_restart_high", 32'(rx_valid_a), 32'd0);
    expect_rx(8'h81, 1'b0, 1'b0);
    drive_frame(8'h81, 0, 1'b0, 1'b1);
    wait_rx(0, "t3r");
    check_rx(0, "t3r");
    consume(0, "t3r");

    // 4: 8-clk glitch in idle
    cyc_n(BIT);
    drv = 1'b0; cyc_n(8); drv = 1'b1;
    cyc_n(12*BIT);
    chk("t4.glitch_ignored", 32'(rx_valid_a), 32'd0);
    expect_rx(8'h5E, 1'b0, 1'b0);
    drive_frame(8'h5E, 0, 1'b0, 1'b1);
    wait_rx(0, "t4");
    check_rx(0, "t4");
    consume(0, "t4");

    // 5: back-to-back frames without consuming -> overrun
    loop_a = 1'b1;
    cyc_n(BIT);
    send_tx(0, 8'h11);
    expect_rx(8'h11, 1'b0, 1'b0);
    tx_data_a = 8'h22; tx_valid_a = 1'b1;   // held while busy
    n = 0;
    while (!tx_ready_a && n < 20*BIT) begin @(negedge clk); n++; end
    @(negedge clk);
    tx_valid_a = 1'b0;
    chk("t5.second_accepted", 32'(tx_ready_a), 32'd0);
    expect_rx(8'h22, 1'b0, 1'b0);
    wait_rx(0, "t5a");
    chk("t5a.overrun", 32'(ov_a), 32'd0);
    check_rx(0, "t5a");
    n = 0;
    while (!ov_a && n < 20*BIT) begin @(negedge clk); n++; end
    chk("t5.overrun_pulse", 32'(ov_a), 32'd1);
    chk("t5.valid_kept", 32'(rx_valid_a), 32'd1);
    check_rx(0, "t5b");
    @(negedge clk);
    chk("t5.overrun_one_cycle", 32'(ov_a), 32'd0);
    consume(0, "t5");

    // 6: reset in the middle of data bit 3 of 0x5A
    cyc_n(BIT);
    send_tx(0, 8'h5A);
    n = 0;
    while (txd_a && n < 4*BIT) begin @(negedge clk); n++; end
    cyc_n(BIT/2 + 4*BIT);
    chk("t6.busy_before_rst", 32'(tx_ready_a), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6.rst_txd", 32'(txd_a), 32'd1);
    chk("t6.rst_tx_ready", 32'(tx_ready_a), 32'd1);
    chk("t6.rst_rx_valid", 32'(rx_valid_a), 32'd0);
    cyc_n(2);
    rst = 1'b0;
    cyc_n(4);
    send_tx(0, 8'h3C);
    expect_rx(8'h3C, 1'b0, 1'b0);
    check_line(0, 8'h3C, 0, "t6");
    wait_rx(0, "t6");
    check_rx(0, "t6");
    consume(0, "t6");
    chk("t6.sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
